// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the load/store path: funct3 widths, fault codes,
// the core's memory-phase state code and the LSU sequencer state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Core control FSM presents this state to data memory while mem_phase is high.
  localparam logic [2:0] MEM_STATE = 3'd6;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_RANGE    = 2'd2,
    FLT_ILLEGAL  = 2'd3
  } fault_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_CAPTURE,
    LSU_FAULT
  } lsu_state_e;

  typedef struct packed {
    logic lb;
    logic lbu;
    logic lh;
    logic lhu;
    logic lw;
    logic sb;
    logic sh;
    logic sw;
  } size_oh_t;

endpackage

// File: rtl/lsu_decode.sv
// Combinational load/store decode: size one-hot, byte count, access address and fault.
// LSU_MISALIGN_TRAP_EN defined: misaligned accesses fault; undefined: address is aligned down.
module lsu_decode
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output size_oh_t    size_oh,
  output logic [2:0]  nbytes,
  output logic [31:0] acc_addr,
  output fault_e      fault
);

  logic        illegal;
  logic        misaligned;
  logic [1:0]  low_bits;
  logic [32:0] last_byte;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    size_oh = '0;
    nbytes  = 3'd1;
    illegal = 1'b0;
    if (is_load == is_store) begin
      illegal = 1'b1;
    end else if (is_load) begin
      case (funct3)
        F3_B:    size_oh.lb  = 1'b1;
        F3_BU:   size_oh.lbu = 1'b1;
        F3_H:    begin size_oh.lh  = 1'b1; nbytes = 3'd2; end
        F3_HU:   begin size_oh.lhu = 1'b1; nbytes = 3'd2; end
        F3_W:    begin size_oh.lw  = 1'b1; nbytes = 3'd4; end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    size_oh.sb = 1'b1;
        F3_H:    begin size_oh.sh = 1'b1; nbytes = 3'd2; end
        F3_W:    begin size_oh.sw = 1'b1; nbytes = 3'd4; end
        default: illegal = 1'b1;
      endcase
    end
  end

  assign low_bits = (nbytes == 3'd4) ? addr[1:0] :
                    (nbytes == 3'd2) ? {1'b0, addr[0]} : 2'b00;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = |low_bits;
  assign acc_addr   = addr;
`else
  assign misaligned = 1'b0;
  assign acc_addr   = {addr[31:2], addr[1:0] & ~low_bits};
`endif

  // 33-bit sum so an access that wraps past 0xFFFFFFFF lands out of range.
  assign last_byte = {1'b0, acc_addr} + {30'd0, nbytes} - 33'd1;

  always_comb begin
    if (illegal)                          fault = FLT_ILLEGAL;
    else if (misaligned)                  fault = FLT_MISALIGN;
    else if (last_byte >= 33'(MEM_BYTES)) fault = FLT_RANGE;
    else                                  fault = FLT_NONE;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of the byte-addressed data memory of the multi-cycle RV32I core.
// Misaligned handling is selected by LSU_MISALIGN_TRAP_EN (trap when defined, align down otherwise).
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  output logic        mem_phase,
  output logic        mem_enabled,
  output logic        mem_load_enable,
  output logic        mem_store_enable,
  output logic        mem_is_lb,
  output logic        mem_is_lbu,
  output logic        mem_is_lh,
  output logic        mem_is_lhu,
  output logic        mem_is_lw,
  output logic        mem_is_sb,
  output logic        mem_is_sh,
  output logic        mem_is_sw,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_fault,
  output logic [31:0] resp_addr
);

  lsu_state_e  state;
  size_oh_t    size_oh_q;
  logic [31:0] addr_q;
  logic        is_load_q;
  logic        resp_load_q;

  logic [31:0] eff_addr;
  size_oh_t    dec_oh;
  logic [2:0]  dec_nbytes_unused;
  logic [31:0] dec_addr;
  fault_e      dec_fault;

  assign eff_addr = base + offset;

  lsu_decode #(
    .MEM_BYTES (MEM_BYTES)
  ) u_decode (
    .is_load  (is_load),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (eff_addr),
    .size_oh  (dec_oh),
    .nbytes   (dec_nbytes_unused),
    .acc_addr (dec_addr),
    .fault    (dec_fault)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= LSU_IDLE;
      req_ready        <= 1'b1;
      mem_phase        <= 1'b0;
      mem_enabled      <= 1'b0;
      mem_load_enable  <= 1'b0;
      mem_store_enable <= 1'b0;
      size_oh_q        <= '0;
      mem_address      <= '0;
      mem_data_in      <= '0;
      addr_q           <= '0;
      is_load_q        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_fault       <= FLT_NONE;
      resp_addr        <= '0;
      resp_load_q      <= 1'b0;
    end else begin
      // Strobes and response fields are single-cycle pulses unless re-asserted below.
      mem_phase        <= 1'b0;
      mem_enabled      <= 1'b0;
      mem_load_enable  <= 1'b0;
      mem_store_enable <= 1'b0;
      size_oh_q        <= '0;
      resp_valid       <= 1'b0;
      resp_fault       <= FLT_NONE;
      resp_addr        <= '0;
      resp_load_q      <= 1'b0;

      case (state)
        LSU_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr_q    <= dec_addr;
            is_load_q <= is_load;
            if (dec_fault != FLT_NONE) begin
              state      <= LSU_FAULT;
              resp_valid <= 1'b1;
              resp_fault <= dec_fault;
              resp_addr  <= dec_addr;
            end else begin
              state            <= LSU_ACCESS;
              mem_phase        <= 1'b1;
              mem_enabled      <= 1'b1;
              mem_load_enable  <= is_load;
              mem_store_enable <= is_store;
              size_oh_q        <= dec_oh;
              mem_address      <= dec_addr;
              mem_data_in      <= store_data;
            end
          end
        end

        LSU_ACCESS: begin
          state       <= LSU_CAPTURE;
          resp_valid  <= 1'b1;
          resp_addr   <= addr_q;
          resp_load_q <= is_load_q;
        end

        default: begin
          state     <= LSU_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: memory registers its read data on the same edge that enters CAPTURE, so the
  // data path is a gate on a registered select rather than another register stage.
  assign resp_data = resp_load_q ? mem_data_out : 32'd0;

  assign mem_is_lb  = size_oh_q.lb;
  assign mem_is_lbu = size_oh_q.lbu;
  assign mem_is_lh  = size_oh_q.lh;
  assign mem_is_lhu = size_oh_q.lhu;
  assign mem_is_lw  = size_oh_q.lw;
  assign mem_is_sb  = size_oh_q.sb;
  assign mem_is_sh  = size_oh_q.sh;
  assign mem_is_sw  = size_oh_q.sw;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a reference model predicts responses and memory accesses,
// negedge monitors pop and compare whatever the DUT presents.
module tb_lsu_ctrl;

  localparam int MEM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic        is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] base, offset, store_data;
  logic        mem_phase, mem_enabled, mem_load_enable, mem_store_enable;
  logic        mem_is_lb, mem_is_lbu, mem_is_lh, mem_is_lhu, mem_is_lw;
  logic        mem_is_sb, mem_is_sh, mem_is_sw;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        resp_valid;
  logic [31:0] resp_data, resp_addr;
  logic [1:0]  resp_fault;

  lsu_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset), .store_data(store_data),
    .mem_phase(mem_phase), .mem_enabled(mem_enabled),
    .mem_load_enable(mem_load_enable), .mem_store_enable(mem_store_enable),
    .mem_is_lb(mem_is_lb), .mem_is_lbu(mem_is_lbu), .mem_is_lh(mem_is_lh),
    .mem_is_lhu(mem_is_lhu), .mem_is_lw(mem_is_lw), .mem_is_sb(mem_is_sb),
    .mem_is_sh(mem_is_sh), .mem_is_sw(mem_is_sw),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
    .resp_addr(resp_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // ---------------- memory behind the DUT ----------------
  logic [7:0]  dmem    [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        load_img;
  logic [11:0] ma;
  logic [31:0] rd_word, ld_val;

  assign ma = mem_address[11:0];

  always_comb begin
    rd_word = {dmem[ma + 12'd3], dmem[ma + 12'd2], dmem[ma + 12'd1], dmem[ma]};
    ld_val  = 32'd0;
    if (mem_is_lb)  ld_val = {{24{rd_word[7]}}, rd_word[7:0]};
    if (mem_is_lbu) ld_val = {24'd0, rd_word[7:0]};
    if (mem_is_lh)  ld_val = {{16{rd_word[15]}}, rd_word[15:0]};
    if (mem_is_lhu) ld_val = {16'd0, rd_word[15:0]};
    if (mem_is_lw)  ld_val = rd_word;
  end

  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < MEM_BYTES; i++) dmem[i] <= ref_mem[i];
      mem_data_out <= 32'd0;
    end else if (mem_enabled) begin
      if (mem_store_enable) begin
        if (mem_is_sb || mem_is_sh || mem_is_sw) dmem[ma] <= mem_data_in[7:0];
        if (mem_is_sh || mem_is_sw)              dmem[ma + 12'd1] <= mem_data_in[15:8];
        if (mem_is_sw) begin
          dmem[ma + 12'd2] <= mem_data_in[23:16];
          dmem[ma + 12'd3] <= mem_data_in[31:24];
        end
      end
      if (mem_load_enable) mem_data_out <= ld_val;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic [1:0]  fault;
    logic [31:0] addr;
    int          cyc;
  } exp_resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  oh;
    logic        st;
    logic [31:0] data;
    int          cyc;
  } exp_acc_t;

  exp_resp_t resp_q[$];
  exp_acc_t  acc_q[$];

  function automatic logic [7:0] exp_oh(input logic ld, input logic [2:0] f3);
    // bit order {lb, lbu, lh, lhu, lw, sb, sh, sw}
    if (ld) begin
      case (f3)
        3'd0:    return 8'h80;
        3'd4:    return 8'h40;
        3'd1:    return 8'h20;
        3'd5:    return 8'h10;
        default: return 8'h08;
      endcase
    end
    case (f3)
      3'd0:    return 8'h04;
      3'd1:    return 8'h02;
      default: return 8'h01;
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail_event("req_ready_timeout", "req_ready stayed 0, expected 1 within 20 cycles");
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] b, input logic [31:0] o, input logic [31:0] sd);
    exp_resp_t   r;
    exp_acc_t    a;
    logic [31:0] addr, v;
    int          nb;
    bit          illegal, misal, range_err;

    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    wait_ready();

    addr    = b + o;
    illegal = (ld == st) || (ld && (f3 == 3'd3 || f3 >= 3'd6)) || (st && f3 >= 3'd3);
    nb      = 1 << f3[1:0];
    misal   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misal = !illegal && (addr % nb != 0);
`else
    if (!illegal) addr = addr - (addr % nb);
`endif
    range_err = !illegal && (longint'({32'd0, addr}) + nb - 1 >= MEM_BYTES);

    r.addr = addr;
    r.data = 32'd0;
    if (illegal)        r.fault = 2'd3;
    else if (misal)     r.fault = 2'd1;
    else if (range_err) r.fault = 2'd2;
    else                r.fault = 2'd0;
    r.cyc = cyc + ((r.fault != 2'd0) ? 1 : 2);

    if (r.fault == 2'd0) begin
      a.addr = addr;
      a.oh   = exp_oh(ld, f3);
      a.st   = st;
      a.data = sd;
      a.cyc  = cyc + 1;
      acc_q.push_back(a);
      if (st) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = sd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
        if (!f3[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
        r.data = v;
      end
    end
    resp_q.push_back(r);

    is_load = ld; is_store = st; funct3 = f3;
    base = b; offset = o; store_data = sd;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Keep presenting a junk request while busy; it must not be accepted.
    req_valid  = 1'($urandom_range(0, 1));
    is_load    = 1'b1; is_store = 1'b0; funct3 = 3'd2;
    base       = $urandom & 32'h0000_0FFC; offset = 32'd0;
    store_data = $urandom;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : monitor
    exp_resp_t  r;
    exp_acc_t   a;
    logic [7:0] oh;
    if (!rst) begin
      oh = {mem_is_lb, mem_is_lbu, mem_is_lh, mem_is_lhu, mem_is_lw, mem_is_sb, mem_is_sh, mem_is_sw};
      if (mem_enabled) begin
        if (acc_q.size() == 0) begin
          fail_event("unexpected_access", $sformatf("mem_enabled at addr 0x%08h with none expected", mem_address));
        end else begin
          a = acc_q.pop_front();
          check("acc_cycle", cyc, a.cyc);
          check("acc_addr", mem_address, a.addr);
          check("acc_size_oh", {24'd0, oh}, {24'd0, a.oh});
          check("acc_phase_ld_st", {29'd0, mem_phase, mem_load_enable, mem_store_enable},
                {29'd0, 1'b1, !a.st, a.st});
          if (a.st) check("acc_store_data", mem_data_in, a.data);
        end
      end else begin
        check("idle_strobes", {21'd0, mem_phase, mem_load_enable, mem_store_enable, oh}, 32'd0);
      end

      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          fail_event("unexpected_resp", $sformatf("resp_valid with addr 0x%08h, none expected", resp_addr));
        end else begin
          r = resp_q.pop_front();
          check("resp_cycle", cyc, r.cyc);
          check("resp_fault", {30'd0, resp_fault}, {30'd0, r.fault});
          check("resp_addr", resp_addr, r.addr);
          check("resp_data", resp_data, r.data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; load_img = 1'b1;
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    base = 32'd0; offset = 32'd0; store_data = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
    ref_mem[16'h104] = 8'hEF; ref_mem[16'h105] = 8'hBE;
    ref_mem[16'h106] = 8'hAD; ref_mem[16'h107] = 8'hDE;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_strobes", {20'd0, mem_phase, mem_enabled, mem_load_enable, mem_store_enable,
          mem_is_lb, mem_is_lbu, mem_is_lh, mem_is_lhu, mem_is_lw, mem_is_sb, mem_is_sh, mem_is_sw}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_addr", resp_addr, 32'd0);
    load_img = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed cases: ld, st, funct3, base, offset, store_data
    issue(1, 0, 3'd2, 32'h100, 32'd4, 32'd0);                 // lw 0x104
    issue(0, 1, 3'd1, 32'h200, 32'd2, 32'h1234ABCD);          // sh 0x202
    issue(1, 0, 3'd5, 32'h200, 32'd2, 32'd0);                 // lhu 0x202
    issue(1, 0, 3'd2, 32'hF0, 32'hE, 32'd0);                  // lw 0x0FE
    issue(1, 0, 3'd2, 32'hFF0, 32'hD, 32'd0);                 // lw 0xFFD
    issue(0, 1, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0000_005A);   // sb wraps to 0
    issue(1, 0, 3'd4, 32'd0, 32'd0, 32'd0);                   // lbu 0x000
    issue(1, 0, 3'd3, 32'h10, 32'd0, 32'd0);                  // load funct3=3
    issue(1, 1, 3'd2, 32'h10, 32'd0, 32'd0);                  // load and store
    issue(0, 0, 3'd2, 32'h10, 32'd0, 32'd0);                  // neither
    issue(0, 1, 3'd4, 32'h10, 32'd0, 32'd0);                  // store funct3=4
    issue(1, 0, 3'd0, 32'h1000, 32'd0, 32'd0);                // lb first byte past end
    issue(1, 0, 3'd2, 32'hFFC, 32'd0, 32'd0);                 // lw last word
    issue(1, 0, 3'd1, 32'hFFF, 32'd0, 32'd0);                 // lh 0xFFF
    issue(1, 0, 3'd2, 32'h10, 32'hFFFF_FFEC, 32'd0);          // wraps to 0xFFFFFFFC
    issue(0, 1, 3'd0, 32'hFFF, 32'd0, 32'hA5A5_A5C3);         // sb last byte

    // Reset in the middle of a store access.
    wait_ready();
    is_load = 1'b0; is_store = 1'b1; funct3 = 3'd2;
    base = 32'h300; offset = 32'd0; store_data = 32'hCAFE_F00D;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_mid_access_active", {29'd0, mem_enabled, mem_store_enable, mem_is_sw}, 32'd7);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_strobes", {21'd0, mem_phase, mem_enabled, mem_load_enable, mem_store_enable,
          mem_is_lb, mem_is_lh, mem_is_lw, mem_is_sb, mem_is_sh, mem_is_sw, resp_valid}, 32'd0);
    check("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(1, 0, 3'd2, 32'h300, 32'd0, 32'd0);                 // old contents must remain

    // Randomised traffic.
    for (int k = 0; k < 250; k++) begin
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] b, o;
      int          sel;
      sel = $urandom_range(0, 15);
      ld  = (sel < 7) || (sel == 14);
      st  = (sel >= 7 && sel < 14) || (sel == 14);
      if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      else                           f3 = 3'($urandom_range(0, 7));
      b = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 'h1080));
      o = 32'($urandom_range(0, 64)) - 32'd32;
      issue(ld, st, f3, b, o, $urandom);
    end

    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("resp_queue_drained", resp_q.size(), 32'd0);
    check("access_queue_drained", acc_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within 2 ms");
    $fatal(1);
  end

endmodule
